// File: rtl/series_job_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : series_job_scheduler_pkg
// Description : Shared types and default sizes for the series job scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package series_job_scheduler_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int XW_DEF      = 8;
  localparam int RW_DEF      = 16;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RETIRE    = 3'd4
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/series_job_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : series_job_scheduler_rr_arbiter
// Description : Combinational round-robin pick among pending jobs, searching
//               upward from rr_ptr_i and wrapping at NREQ.
// Revision    : 1.0 - initial release
// ============================================================================
module series_job_scheduler_rr_arbiter
  import series_job_scheduler_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] pending_i,
  input  logic [IW-1:0]   rr_ptr_i,
  output logic [NREQ-1:0] grant_oh_o,
  output logic [IW-1:0]   grant_idx_o,
  output logic            any_o
);

  logic found;

  // First pending requester at distance k from the pointer wins; the second
  // equality term handles the wrap past NREQ-1 without a modulo operator.
  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && pending_i[j] &&
            ((int'(rr_ptr_i) + k == j) || (int'(rr_ptr_i) + k == j + NREQ))) begin
          found         = 1'b1;
          grant_oh_o[j] = 1'b1;
          grant_idx_o   = IW'(j);
        end
      end
    end
    any_o = found;
  end

endmodule
`default_nettype wire

// File: rtl/series_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : series_job_scheduler
// Description : Queues one job per requester, arbitrates round-robin and runs
//               the shared series engine's start/ready handshake, returning
//               each result with a one-cycle done pulse.
//               Optional feature macro: WATCHDOG_TIMEOUT_EN (engine watchdog
//               producing err/eng_reset and a forced zero result).
// Revision    : 1.0 - initial release
// ============================================================================
module series_job_scheduler
  import series_job_scheduler_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int XW      = XW_DEF,
  parameter int RW      = RW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*XW-1:0] x_in,
  output logic [NREQ-1:0]    req_acc,
  output logic [NREQ-1:0]    done,
  output logic [RW-1:0]      result,
  output logic               busy,
  output logic               eng_start,
  output logic [XW-1:0]      eng_x,
  input  logic               eng_ready,
  input  logic [RW-1:0]      eng_result,
  output logic               err,
  output logic               eng_reset
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_params
    $error("series_job_scheduler: NREQ must be 2..8 and TIMEOUT >= 1");
  end

  sched_state_e    state_q;
  logic [NREQ-1:0] pending_q, pending_d;
  logic [NREQ-1:0] clear_vec, acc_vec;
  logic [XW-1:0]   opnd_q [NREQ];
  logic [IW-1:0]   rr_ptr_q, grant_q;
  logic [NREQ-1:0] done_q;
  logic [RW-1:0]   result_q;
  logic            busy_q, eng_start_q, err_q, eng_reset_q;
  logic [XW-1:0]   eng_x_q, sel_x;
  logic [NREQ-1:0] arb_oh;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

`ifdef WATCHDOG_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt_q;
  logic          wd_hit;
  assign wd_hit = (wd_cnt_q == CW'(TIMEOUT));
`endif

  series_job_scheduler_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arbiter (
    .pending_i   (pending_q),
    .rr_ptr_i    (rr_ptr_q),
    .grant_oh_o  (arb_oh),
    .grant_idx_o (arb_idx),
    .any_o       (arb_any)
  );

  // Accept/clear the per-requester job slots; a set in RETIRE beats the clear.
  always_comb begin
    clear_vec = '0;
    if (state_q == ST_RETIRE) begin
      clear_vec[grant_q] = 1'b1;
    end
    acc_vec   = req & (~pending_q | clear_vec);
    pending_d = (pending_q & ~clear_vec) | acc_vec;
  end

  // Operand of the arbitration winner, AND-OR selected by the one-hot grant.
  always_comb begin
    sel_x = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_oh[i]) begin
        sel_x = sel_x | opnd_q[i];
      end
    end
  end

  // Job storage: pending bits and operands latched on acceptance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        opnd_q[i] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      for (int i = 0; i < NREQ; i++) begin
        if (acc_vec[i]) begin
          opnd_q[i] <= x_in[i*XW +: XW];
        end
      end
    end
  end

  // Scheduler state machine with registered handshake and completion outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      eng_x_q     <= '0;
      result_q    <= '0;
      eng_start_q <= 1'b0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      eng_reset_q <= 1'b0;
`ifdef WATCHDOG_TIMEOUT_EN
      wd_cnt_q    <= '0;
`endif
    end else begin
      eng_start_q <= 1'b0;
      done_q      <= '0;
      err_q       <= 1'b0;
      eng_reset_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            grant_q     <= arb_idx;
            eng_x_q     <= sel_x;
            eng_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT_BUSY;
`ifdef WATCHDOG_TIMEOUT_EN
          wd_cnt_q <= '0;
`endif
        end
        ST_WAIT_BUSY: begin
`ifdef WATCHDOG_TIMEOUT_EN
          wd_cnt_q <= wd_cnt_q + 1'b1;
          if (wd_hit) begin
            result_q        <= '0;
            done_q[grant_q] <= 1'b1;
            err_q           <= 1'b1;
            eng_reset_q     <= 1'b1;
            state_q         <= ST_RETIRE;
          end else if (!eng_ready) begin
            state_q <= ST_WAIT_DONE;
          end
`else
          if (!eng_ready) begin
            state_q <= ST_WAIT_DONE;
          end
`endif
        end
        ST_WAIT_DONE: begin
          if (eng_ready) begin
            result_q        <= eng_result;
            done_q[grant_q] <= 1'b1;
            state_q         <= ST_RETIRE;
          end
`ifdef WATCHDOG_TIMEOUT_EN
          else if (wd_hit) begin
            result_q        <= '0;
            done_q[grant_q] <= 1'b1;
            err_q           <= 1'b1;
            eng_reset_q     <= 1'b1;
            state_q         <= ST_RETIRE;
          end
          wd_cnt_q <= wd_cnt_q + 1'b1;
`endif
        end
        ST_RETIRE: begin
          rr_ptr_q <= (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_acc   = acc_vec;
  assign done      = done_q;
  assign result    = result_q;
  assign busy      = busy_q;
  assign eng_start = eng_start_q;
  assign eng_x     = eng_x_q;

`ifdef WATCHDOG_TIMEOUT_EN
  assign err       = err_q;
  assign eng_reset = eng_reset_q;
`else
  assign err       = 1'b0;
  assign eng_reset = 1'b0;
`endif

endmodule
`default_nettype wire
